// File: rtl/seq_shifter_pkg.sv
// rtl/seq_shifter_pkg.sv - op and state encodings shared by the shifter modules
package seq_shifter_pkg;

  typedef enum logic [1:0] {
    OP_SRL = 2'b00,
    OP_SRA = 2'b01,
    OP_SLL = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/seq_shifter_shift_one_step.sv
// rtl/seq_shifter_shift_one_step.sv - combinational single-bit shift/rotate step
module shift_one_step
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] next_value,
  output logic             shift_out
);

  always_comb begin
    next_value = value;
    shift_out  = 1'b0;
    case (op)
      OP_SRL: begin
        next_value = {1'b0, value[WIDTH-1:1]};
        shift_out  = value[0];
      end
      OP_SRA: begin
        next_value = {value[WIDTH-1], value[WIDTH-1:1]};
        shift_out  = value[0];
      end
      OP_SLL: begin
        next_value = {value[WIDTH-2:0], 1'b0};
        shift_out  = value[WIDTH-1];
      end
      OP_ROR: begin
        next_value = {value[0], value[WIDTH-1:1]};
        shift_out  = value[0];
      end
      default: begin
        next_value = value;
        shift_out  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - multi-cycle shift/rotate unit, one bit per clock
// Optional carry_out port and logic enabled by SHIFTER_CARRY_EN.
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out
`ifdef SHIFTER_CARRY_EN
  ,
  output logic             carry_out
`endif
);

  localparam logic [AMT_W-1:0] MAX_AMT = AMT_W'(WIDTH - 1);
  localparam logic [AMT_W-1:0] ONE     = AMT_W'(1);

  state_e           state_q;
  state_e           state_d;
  op_e              op_q;
  logic [AMT_W-1:0] count_q;
  logic [WIDTH-1:0] work_q;
  logic [AMT_W-1:0] amt_clamped;
  logic [WIDTH-1:0] step_value;
  logic             step_out;

  // Out-of-range amounts saturate to the widest legal shift.
  assign amt_clamped = (amount > MAX_AMT) ? MAX_AMT : amount;

  shift_one_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .op        (op_q),
    .value     (work_q),
    .next_value(step_value),
    .shift_out (step_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_DONE);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (amt_clamped == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (count_q == ONE) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Result registers load only on the edge that enters DONE and hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= OP_SRL;
      count_q  <= '0;
      work_q   <= '0;
      data_out <= '0;
`ifdef SHIFTER_CARRY_EN
      carry_out <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q    <= op_e'(op);
            work_q  <= data_in;
            count_q <= amt_clamped;
            if (amt_clamped == '0) begin
              data_out <= data_in;
`ifdef SHIFTER_CARRY_EN
              carry_out <= 1'b0;
`endif
            end
          end
        end
        ST_SHIFT: begin
          work_q  <= step_value;
          count_q <= count_q - ONE;
          if (count_q == ONE) begin
            data_out <= step_value;
`ifdef SHIFTER_CARRY_EN
            carry_out <= step_out;
`endif
          end
        end
        default: begin
          work_q <= work_q;
        end
      endcase
    end
  end

`ifndef SHIFTER_CARRY_EN
  wire unused_step_out = step_out;
`endif

endmodule

// File: tb/tb_seq_shifter.sv
// tb/tb_seq_shifter.sv - scoreboard bench for seq_shifter at widths 8, 16 and 6
module tb_seq_shifter;

  typedef struct {
    logic [15:0] data;
    logic        carry;
    int          lat;
    int          sc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int          widths[3] = '{8, 16, 6};
  logic        start_a[3];
  logic [1:0]  op_a[3];
  logic [3:0]  amt_a[3];
  logic [15:0] din_a[3];
  logic        busy_a[3];
  logic        done_a[3];
  logic [15:0] dout_a[3];
  logic        carry_a[3];
  exp_t        q[3][$];

  logic        busy0, busy1, busy2, done0, done1, done2;
  logic [7:0]  dout0;
  logic [15:0] dout1;
  logic [5:0]  dout2;
  logic        carry0, carry1, carry2;

  seq_shifter #(.WIDTH(8), .AMT_W(3)) u_s8 (
    .clk(clk), .reset(reset), .start(start_a[0]), .op(op_a[0]),
    .amount(amt_a[0][2:0]), .data_in(din_a[0][7:0]),
    .busy(busy0), .done(done0), .data_out(dout0)
`ifdef SHIFTER_CARRY_EN
    , .carry_out(carry0)
`endif
  );

  seq_shifter #(.WIDTH(16), .AMT_W(4)) u_s16 (
    .clk(clk), .reset(reset), .start(start_a[1]), .op(op_a[1]),
    .amount(amt_a[1]), .data_in(din_a[1]),
    .busy(busy1), .done(done1), .data_out(dout1)
`ifdef SHIFTER_CARRY_EN
    , .carry_out(carry1)
`endif
  );

  seq_shifter #(.WIDTH(6), .AMT_W(3)) u_s6 (
    .clk(clk), .reset(reset), .start(start_a[2]), .op(op_a[2]),
    .amount(amt_a[2][2:0]), .data_in(din_a[2][5:0]),
    .busy(busy2), .done(done2), .data_out(dout2)
`ifdef SHIFTER_CARRY_EN
    , .carry_out(carry2)
`endif
  );

`ifndef SHIFTER_CARRY_EN
  assign carry0 = 1'b0;
  assign carry1 = 1'b0;
  assign carry2 = 1'b0;
`endif

  always_comb begin
    busy_a[0] = busy0;  busy_a[1] = busy1;  busy_a[2] = busy2;
    done_a[0] = done0;  done_a[1] = done1;  done_a[2] = done2;
    dout_a[0] = {8'h00, dout0};
    dout_a[1] = dout1;
    dout_a[2] = {10'h000, dout2};
    carry_a[0] = carry0; carry_a[1] = carry1; carry_a[2] = carry2;
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Whole-shift reference: shift by the full amount at once with plain arithmetic.
  function automatic exp_t model(int w, logic [1:0] o, int a, logic [15:0] d);
    exp_t        e;
    logic [31:0] mask, x, r;
    mask = (32'd1 << w) - 32'd1;
    x    = {16'h0, d} & mask;
    case (o)
      2'd0: r = x >> a;
      2'd1: begin
        r = x >> a;
        if (x[w-1]) r = r | (mask & ~(mask >> a));
      end
      2'd2: r = (x << a) & mask;
      default: r = ((x >> a) | (x << (w - a))) & mask;
    endcase
    e.data  = r[15:0];
    e.carry = (a == 0) ? 1'b0 : ((o == 2'd2) ? x[w-a] : x[a-1]);
    e.lat   = a + 1;
    e.sc    = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        if (done_a[i]) begin
          chk($sformatf("done_expected[%0d]", i), 32'(q[i].size() != 0), 32'd1);
          if (q[i].size() != 0) begin
            exp_t e;
            e = q[i].pop_front();
            chk($sformatf("data_out[%0d]", i), {16'h0, dout_a[i]}, {16'h0, e.data});
`ifdef SHIFTER_CARRY_EN
            chk($sformatf("carry_out[%0d]", i), 32'(carry_a[i]), 32'(e.carry));
`endif
            chk($sformatf("latency[%0d]", i), 32'(cyc - e.sc + 1), 32'(e.lat));
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge right after the capture edge.
  task automatic issue(int i, logic [1:0] o, logic [3:0] a, logic [15:0] d);
    int   g = 0;
    int   ea;
    exp_t e;
    while (busy_a[i] && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk($sformatf("idle_wait[%0d]", i), 32'(busy_a[i]), 32'd0);
    ea = (int'(a) >= widths[i]) ? widths[i] - 1 : int'(a);
    op_a[i] = o; amt_a[i] = a; din_a[i] = d; start_a[i] = 1'b1;
    e = model(widths[i], o, ea, d);
    e.sc = cyc + 1;
    q[i].push_back(e);
    @(negedge clk);
    start_a[i] = 1'b0;
    op_a[i] = 2'($urandom);
    amt_a[i] = 4'($urandom);
    din_a[i] = 16'($urandom);
  endtask

  task automatic count_busy(int i, int exp_n, string name);
    int n = 0;
    while (busy_a[i] && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk(name, 32'(n), 32'(exp_n));
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      start_a[i] = 1'b0; op_a[i] = 2'd0; amt_a[i] = 4'd0; din_a[i] = 16'd0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_busy[%0d]", i), 32'(busy_a[i]), 32'd0);
      chk($sformatf("reset_done[%0d]", i), 32'(done_a[i]), 32'd0);
      chk($sformatf("reset_data_out[%0d]", i), {16'h0, dout_a[i]}, 32'd0);
`ifdef SHIFTER_CARRY_EN
      chk($sformatf("reset_carry[%0d]", i), 32'(carry_a[i]), 32'd0);
`endif
    end

    issue(0, 2'd0, 4'd3, 16'h00B4);
    count_busy(0, 4, "srl_busy_cycles");
    issue(0, 2'd1, 4'd2, 16'h00B4);
    issue(0, 2'd2, 4'd1, 16'h0081);
    issue(0, 2'd3, 4'd7, 16'h0001);
    issue(0, 2'd2, 4'd0, 16'h005A);
    chk("amt0_busy_done_cycle", 32'(busy_a[0]), 32'd1);
    count_busy(0, 1, "amt0_busy_cycles");

    issue(0, 2'd0, 4'd5, 16'h00B4);
    for (int g = 0; g < 50 && busy_a[0]; g++) begin
      start_a[0] = 1'b1; op_a[0] = 2'd2; amt_a[0] = 4'd1; din_a[0] = 16'h00FF;
      @(negedge clk);
    end
    start_a[0] = 1'b0;
    chk("ignored_start_data", {16'h0, dout_a[0]}, 32'h05);
    @(negedge clk);
    chk("ignored_start_no_restart", 32'(busy_a[0]), 32'd0);
    issue(0, 2'd1, 4'd2, 16'h00B4);
    chk("data_out_held_on_start", {16'h0, dout_a[0]}, 32'h05);
    count_busy(0, 3, "sra_busy_cycles");

    issue(0, 2'd0, 4'd7, 16'h00F0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_busy", 32'(busy_a[0]), 32'd0);
    chk("async_reset_done", 32'(done_a[0]), 32'd0);
    chk("async_reset_data_out", {16'h0, dout_a[0]}, 32'd0);
    q[0].delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    issue(0, 2'd1, 4'd7, 16'h0080);
    count_busy(0, 8, "sra7_busy_cycles");

    issue(2, 2'd0, 4'd7, 16'h003F);
    issue(2, 2'd2, 4'd6, 16'h0021);

    fork
      for (int n = 0; n < 400; n++)
        issue(0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 7)), 16'($urandom));
      for (int n = 0; n < 500; n++)
        issue(1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 16'($urandom));
      for (int n = 0; n < 100; n++)
        issue(2, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 7)), 16'($urandom));
    join

    for (int g = 0; g < 100 && (q[0].size() + q[1].size() + q[2].size()) != 0; g++)
      @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("scoreboard_drained[%0d]", i), 32'(q[i].size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
